// File: rtl/sha256_padder.sv
// SHA-256 message padder: turns one registered message of up to 512 bits into one or two
// padded 512-bit blocks (message, single '1' bit, zero fill, 64-bit bit-length field).
module sha256_padder #(
    parameter int unsigned MSG_NIBBLES = 128
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [MSG_NIBBLES-1:0][3:0] mess,
    input  logic [31:0]                 size,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [511:0]                out_block,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        len_err
);

    typedef enum logic [1:0] {
        StIdle,
        StBlk0,
        StBlk1
    } state_e;

    state_e                        r_state;
    state_e                        w_state_next;
    logic [MSG_NIBBLES-1:0][3:0]   r_mess;
    logic [31:0]                   r_size;
    logic                          r_len_err;

    logic                          w_accept;
    logic                          w_legal;
    logic                          w_two;
    logic [8:0]                    w_pad_idx;
    logic [511:0]                  w_blk0;
    logic [511:0]                  w_blk1;

    assign w_accept  = in_valid && in_ready;
    assign w_legal   = (size <= 32'd512) && (size[1:0] == 2'b00);
    // Legal sizes are multiples of 4, so anything above 444 needs a second block.
    assign w_two     = (r_size > 32'd444);
    assign w_pad_idx = 9'd511 - r_size[8:0];
    assign len_err   = r_len_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= StIdle;
            r_len_err <= 1'b0;
            r_mess    <= '0;
            r_size    <= '0;
        end else begin
            r_state   <= w_state_next;
            r_len_err <= w_accept && !w_legal;
            if (w_accept && w_legal) begin
                r_mess <= mess;
                r_size <= size;
            end
        end
    end

    always_comb begin
        w_blk0 = '0;
        for (int unsigned i = 0; i < MSG_NIBBLES; i++) begin
            if (i < (r_size >> 2)) begin
                w_blk0[511 - 4*i -: 4] = r_mess[i];
            end
        end
        if (r_size < 32'd512) begin
            w_blk0[w_pad_idx] = 1'b1;
        end
        if (!w_two) begin
            w_blk0[63:0] = {32'd0, r_size};
        end
    end

    assign w_blk1 = {(r_size == 32'd512), 447'd0, 32'd0, r_size};

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        out_last     = 1'b0;
        out_block    = '0;
        unique case (r_state)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid && w_legal) begin
                    w_state_next = StBlk0;
                end
            end
            StBlk0: begin
                out_valid = 1'b1;
                out_block = w_blk0;
                out_last  = !w_two;
                if (out_ready) begin
                    w_state_next = w_two ? StBlk1 : StIdle;
                end
            end
            StBlk1: begin
                out_valid = 1'b1;
                out_block = w_blk1;
                out_last  = 1'b1;
                if (out_ready) begin
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

endmodule
